gen_bank_controller: RTL and testbench

//  Ping-pong controller for the two Game-of-Life generation BRAMs (A, B); successor to the fixed mode mux.

---
 rtl/gol_pkg.sv | 11 +
 rtl/bank_port_mux.sv | 34 +++
 rtl/gen_bank_controller.sv | 129 ++++++++++++
 tb/tb_gen_bank_controller.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/gol_pkg.sv
// gol_pkg: shared FSM state encoding and bank identifiers for the generation ping-pong controller
package gol_pkg;
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    COMPUTE    = 2'd1,
    WAIT_FRAME = 2'd2,
    SWAP       = 2'd3
  } state_t;
  localparam logic BANK_A = 1'b0;
  localparam logic BANK_B = 1'b1;
endpackage

// File: rtl/bank_port_mux.sv
// bank_port_mux: steers one BRAM's ports according to whether it is currently the read or write bank
module bank_port_mux
  import gol_pkg::*;
#(
  parameter int   X_SIZE  = 1280,
  parameter int   Y_WIDTH = 10,
  parameter logic BANK    = BANK_A
) (
  input  logic               read_bank_i,
  input  logic               idle_i,
  input  logic               ui_we_i,
  input  logic               wr_ok_i,
  input  logic [Y_WIDTH-1:0] ui_addr_i,
  input  logic [X_SIZE-1:0]  ui_data_i,
  input  logic [Y_WIDTH-1:0] fetch_addr_i,
  input  logic [Y_WIDTH-1:0] vid_addr_i,
  input  logic [Y_WIDTH-1:0] wr_addr_i,
  input  logic [X_SIZE-1:0]  wr_data_i,
  input  logic               wr_en_i,
  output logic [Y_WIDTH-1:0] addra_o,
  output logic [X_SIZE-1:0]  dina_o,
  output logic               wea_o,
  output logic [Y_WIDTH-1:0] addrb_o
);
  logic is_read;
  assign is_read = (read_bank_i == BANK);
  // read bank serves fetch/UI on port A, write bank takes engine writes; port B always follows video
  always_comb begin
    addra_o = is_read ? (idle_i ? ui_addr_i : fetch_addr_i) : wr_addr_i;
    dina_o  = is_read ? ui_data_i : wr_data_i;
    wea_o   = is_read ? ui_we_i : (wr_ok_i & wr_en_i);
    addrb_o = vid_addr_i;
  end
endmodule

// File: rtl/gen_bank_controller.sv
// gen_bank_controller: ping-pong sequencing of the two generation BRAMs with tear-free frame-end swaps
module gen_bank_controller
  import gol_pkg::*;
#(
  parameter int X_SIZE    = 1280,
  parameter int Y_SIZE    = 720,
  parameter int Y_WIDTH   = 10,
  parameter int GEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 step,
  output logic                 gen_start,
  input  logic                 gen_done,
  input  logic                 frame_end,
  input  logic                 ui_wr_en,
  input  logic [Y_WIDTH-1:0]   ui_addr,
  input  logic [X_SIZE-1:0]    ui_data,
  input  logic [Y_WIDTH-1:0]   fetch_addr,
  output logic [X_SIZE-1:0]    fetch_data,
  input  logic [Y_WIDTH-1:0]   wr_addr,
  input  logic [X_SIZE-1:0]    wr_data,
  input  logic                 wr_en,
  input  logic [Y_WIDTH-1:0]   vid_addr,
  output logic [X_SIZE-1:0]    vid_data,
  output logic [Y_WIDTH-1:0]   BRAM_A_addra,
  output logic [X_SIZE-1:0]    BRAM_A_dina,
  output logic                 BRAM_A_wea,
  input  logic [X_SIZE-1:0]    BRAM_A_douta,
  output logic [Y_WIDTH-1:0]   BRAM_A_addrb,
  input  logic [X_SIZE-1:0]    BRAM_A_doutb,
  output logic [Y_WIDTH-1:0]   BRAM_B_addra,
  output logic [X_SIZE-1:0]    BRAM_B_dina,
  output logic                 BRAM_B_wea,
  input  logic [X_SIZE-1:0]    BRAM_B_douta,
  output logic [Y_WIDTH-1:0]   BRAM_B_addrb,
  input  logic [X_SIZE-1:0]    BRAM_B_doutb,
  output logic                 read_bank,
  output logic                 busy,
  output logic [GEN_WIDTH-1:0] gen_count
);
  state_t               state_q, state_d;
  logic                 read_bank_q, read_bank_d;
  logic                 rd_sel_q;
  logic                 gen_start_q, gen_start_d;
  logic [GEN_WIDTH-1:0] gen_count_q, gen_count_d;
  logic                 idle, ui_we, wr_ok;
  assign idle  = (state_q == IDLE);
  assign ui_we = ~rst & idle & ~run & ui_wr_en;
  assign wr_ok = ~rst & (state_q == COMPUTE);
  // next-state: start on run/step in IDLE, wait for engine, then for frame end, then swap
  always_comb begin
    state_d     = state_q;
    gen_start_d = 1'b0;
    read_bank_d = read_bank_q;
    gen_count_d = gen_count_q;
    unique case (state_q)
      IDLE: if (run | step) begin
        state_d     = COMPUTE;
        gen_start_d = 1'b1;
      end
      COMPUTE:    if (gen_done) state_d = frame_end ? SWAP : WAIT_FRAME;
      WAIT_FRAME: if (frame_end) state_d = SWAP;
      SWAP: begin
        state_d     = IDLE;
        read_bank_d = ~read_bank_q;
        gen_count_d = gen_count_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers; rd_sel_q trails read_bank by the BRAM read latency
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      read_bank_q <= BANK_A;
      rd_sel_q    <= BANK_A;
      gen_start_q <= 1'b0;
      gen_count_q <= '0;
    end else begin
      state_q     <= state_d;
      read_bank_q <= read_bank_d;
      rd_sel_q    <= read_bank_q;
      gen_start_q <= gen_start_d;
      gen_count_q <= gen_count_d;
    end
  end
  assign gen_start  = gen_start_q;
  assign read_bank  = read_bank_q;
  assign gen_count  = gen_count_q;
  assign busy       = ~idle;
  assign fetch_data = (rd_sel_q == BANK_B) ? BRAM_B_douta : BRAM_A_douta;
  assign vid_data   = (rd_sel_q == BANK_B) ? BRAM_B_doutb : BRAM_A_doutb;
  bank_port_mux #(.X_SIZE(X_SIZE), .Y_WIDTH(Y_WIDTH), .BANK(BANK_A)) u_mux_a (
    .read_bank_i (read_bank_q),
    .idle_i      (idle),
    .ui_we_i     (ui_we),
    .wr_ok_i     (wr_ok),
    .ui_addr_i   (ui_addr),
    .ui_data_i   (ui_data),
    .fetch_addr_i(fetch_addr),
    .vid_addr_i  (vid_addr),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .wr_en_i     (wr_en),
    .addra_o     (BRAM_A_addra),
    .dina_o      (BRAM_A_dina),
    .wea_o       (BRAM_A_wea),
    .addrb_o     (BRAM_A_addrb)
  );
  bank_port_mux #(.X_SIZE(X_SIZE), .Y_WIDTH(Y_WIDTH), .BANK(BANK_B)) u_mux_b (
    .read_bank_i (read_bank_q),
    .idle_i      (idle),
    .ui_we_i     (ui_we),
    .wr_ok_i     (wr_ok),
    .ui_addr_i   (ui_addr),
    .ui_data_i   (ui_data),
    .fetch_addr_i(fetch_addr),
    .vid_addr_i  (vid_addr),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .wr_en_i     (wr_en),
    .addra_o     (BRAM_B_addra),
    .dina_o      (BRAM_B_dina),
    .wea_o       (BRAM_B_wea),
    .addrb_o     (BRAM_B_addrb)
  );
endmodule

// File: tb/tb_gen_bank_controller.sv
// tb_gen_bank_controller: directed checks of sequencing, bank roles, UI edits, reset and counter wrap
module tb_gen_bank_controller;
  localparam int X = 1280;
  localparam int YW = 10;
  localparam int GW = 16;
  logic          clk = 1'b0;
  logic          rst, run, step, gen_start, gen_done, frame_end, ui_wr_en, wr_en;
  logic [YW-1:0] ui_addr, fetch_addr, wr_addr, vid_addr;
  logic [X-1:0]  ui_data, wr_data, fetch_data, vid_data;
  logic [YW-1:0] a_addra, a_addrb, b_addra, b_addrb;
  logic [X-1:0]  a_dina, b_dina, a_douta, a_doutb, b_douta, b_doutb;
  logic          a_wea, b_wea, read_bank, busy;
  logic [GW-1:0] gen_count;
  int            n_cmp = 0;
  int            n_bad = 0;
  int            n_starts = 0;
  always #5 clk = ~clk;
  always @(posedge clk) if (gen_start) n_starts <= n_starts + 1;
  gen_bank_controller dut (
    .clk(clk), .rst(rst), .run(run), .step(step), .gen_start(gen_start),
    .gen_done(gen_done), .frame_end(frame_end), .ui_wr_en(ui_wr_en),
    .ui_addr(ui_addr), .ui_data(ui_data), .fetch_addr(fetch_addr),
    .fetch_data(fetch_data), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_en(wr_en), .vid_addr(vid_addr), .vid_data(vid_data),
    .BRAM_A_addra(a_addra), .BRAM_A_dina(a_dina), .BRAM_A_wea(a_wea),
    .BRAM_A_douta(a_douta), .BRAM_A_addrb(a_addrb), .BRAM_A_doutb(a_doutb),
    .BRAM_B_addra(b_addra), .BRAM_B_dina(b_dina), .BRAM_B_wea(b_wea),
    .BRAM_B_douta(b_douta), .BRAM_B_addrb(b_addrb), .BRAM_B_doutb(b_doutb),
    .read_bank(read_bank), .busy(busy), .gen_count(gen_count)
  );
  task automatic chk(input string tag, input logic [X-1:0] obs, input logic [X-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs[63:0], exp[63:0]);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1; run = 1'b0; step = 1'b0; gen_done = 1'b0; frame_end = 1'b0;
    ui_wr_en = 1'b1; ui_addr = 10'd5; ui_data = '1;
    wr_en = 1'b1; wr_addr = 10'd719; wr_data = {20{64'h0123_4567_89AB_CDEF}};
    fetch_addr = 10'd17; vid_addr = 10'd42;
    a_douta = {20{64'hAAAA_0000_AAAA_0001}}; b_douta = {20{64'hBBBB_0000_BBBB_0001}};
    a_doutb = {20{64'hAAAA_1111_AAAA_2222}}; b_doutb = {20{64'hBBBB_1111_BBBB_2222}};
    tick; tick;
    chk("rst_busy", X'(busy), X'(0));
    chk("rst_read_bank", X'(read_bank), X'(0));
    chk("rst_gen_count", X'(gen_count), X'(0));
    chk("rst_gen_start", X'(gen_start), X'(0));
    chk("rst_a_wea", X'(a_wea), X'(0));
    chk("rst_b_wea", X'(b_wea), X'(0));
    rst = 1'b0; ui_wr_en = 1'b0; wr_en = 1'b0;
    tick;
    // paused UI edit lands in read bank A
    ui_wr_en = 1'b1; ui_addr = 10'd5; ui_data = '1;
    #1;
    chk("ui_a_wea", X'(a_wea), X'(1));
    chk("ui_a_addra", X'(a_addra), X'(5));
    chk("ui_a_dina", a_dina, '1);
    chk("ui_b_wea", X'(b_wea), X'(0));
    chk("vid_b_addrb", X'(b_addrb), X'(42));
    run = 1'b1;
    #1;
    chk("ui_run_a_wea", X'(a_wea), X'(0));
    run = 1'b0; ui_wr_en = 1'b0;
    // single step, second step during COMPUTE ignored
    tick;
    step = 1'b1;
    tick;
    step = 1'b0;
    chk("step_gen_start", X'(gen_start), X'(1));
    chk("step_busy", X'(busy), X'(1));
    tick;
    chk("step_pulse_1cyc", X'(gen_start), X'(0));
    step = 1'b1;
    tick;
    step = 1'b0;
    tick; tick;
    chk("step_starts", X'(n_starts), X'(1));
    chk("compute_a_addra_fetch", X'(a_addra), X'(17));
    // engine writes go only to write bank B
    wr_en = 1'b1; wr_addr = 10'd719;
    #1;
    chk("wr_b_wea", X'(b_wea), X'(1));
    chk("wr_a_wea", X'(a_wea), X'(0));
    chk("wr_b_addra", X'(b_addra), X'(719));
    chk("wr_b_dina", b_dina, wr_data);
    chk("fetch_from_a", fetch_data, a_douta);
    chk("vid_from_a", vid_data, a_doutb);
    wr_en = 1'b0;
    // gen_done with frame_end together swaps on the next cycle
    gen_done = 1'b1; frame_end = 1'b1;
    tick;
    gen_done = 1'b0; frame_end = 1'b0;
    chk("same_swap_busy", X'(busy), X'(1));
    chk("same_swap_rb_pre", X'(read_bank), X'(0));
    tick;
    chk("same_swap_busy_done", X'(busy), X'(0));
    chk("same_swap_rb", X'(read_bank), X'(1));
    chk("same_swap_count", X'(gen_count), X'(1));
    chk("fetch_delay_a", fetch_data, a_douta);
    tick;
    chk("fetch_after_b", fetch_data, b_douta);
    chk("vid_after_b", vid_data, b_doutb);
    // paused UI edit now targets bank B
    ui_wr_en = 1'b1;
    #1;
    chk("ui_b_wea", X'(b_wea), X'(1));
    chk("ui_a_wea_b_read", X'(a_wea), X'(0));
    ui_wr_en = 1'b0;
    // free-run generation waiting 50 cycles for frame end
    run = 1'b1;
    tick;
    run = 1'b0;
    chk("run_gen_start", X'(gen_start), X'(1));
    wr_en = 1'b1; wr_addr = 10'd3;
    #1;
    chk("run_a_wea", X'(a_wea), X'(1));
    chk("run_b_wea", X'(b_wea), X'(0));
    wr_en = 1'b0;
    gen_done = 1'b1;
    tick;
    gen_done = 1'b0;
    repeat (49) tick;
    chk("wait_busy", X'(busy), X'(1));
    chk("wait_rb", X'(read_bank), X'(1));
    wr_en = 1'b1;
    #1;
    chk("wait_a_wea", X'(a_wea), X'(0));
    wr_en = 1'b0;
    frame_end = 1'b1;
    tick;
    frame_end = 1'b0;
    chk("swap_state_rb", X'(read_bank), X'(1));
    chk("swap_state_busy", X'(busy), X'(1));
    tick;
    chk("run_swap_rb", X'(read_bank), X'(0));
    chk("run_swap_count", X'(gen_count), X'(2));
    chk("run_swap_idle", X'(busy), X'(0));
    // reset during COMPUTE aborts the generation
    step = 1'b1;
    tick;
    step = 1'b0;
    chk("abort_busy_pre", X'(busy), X'(1));
    wr_en = 1'b1;
    rst = 1'b1;
    #1;
    chk("abort_a_wea", X'(a_wea), X'(0));
    chk("abort_b_wea", X'(b_wea), X'(0));
    tick;
    rst = 1'b0; wr_en = 1'b0;
    chk("abort_busy", X'(busy), X'(0));
    chk("abort_rb", X'(read_bank), X'(0));
    chk("abort_count", X'(gen_count), X'(0));
    // counter wraps from all-ones to zero
    force dut.gen_count_q = 16'hFFFF;
    #1;
    release dut.gen_count_q;
    #1;
    chk("wrap_preset", X'(gen_count), X'(16'hFFFF));
    step = 1'b1;
    tick;
    step = 1'b0;
    gen_done = 1'b1; frame_end = 1'b1;
    tick;
    gen_done = 1'b0; frame_end = 1'b0;
    tick;
    chk("wrap_count", X'(gen_count), X'(0));
    chk("wrap_rb", X'(read_bank), X'(1));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
